// File: rtl/pciea_dbg_pkg.sv
// Shared types and widths for the PCIe debug select sampler and its record FIFO.
// Optional CCIX capture is compiled in with PCIEA_DBG_CCIX_CAPTURE_EN; the record
// struct then carries a ccix field that follows the channel 0 snapshot.
package pciea_dbg_pkg;

    localparam int DBG_DATA_W = 256;
    localparam int DBG_CTRL_W = 32;
    localparam int DBG_SEL_W  = 6;
    localparam int DBG_CCIX_W = 130;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUSH0,
        ST_PUSH1,
        ST_NEXT
    } dbg_state_t;

    typedef struct packed {
        logic [DBG_DATA_W-1:0] data;
        logic [DBG_CTRL_W-1:0] ctrl;
        logic [DBG_SEL_W-1:0]  sel;
        logic                  ch;
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
        logic [DBG_CCIX_W-1:0] ccix;
`endif
    } dbg_rec_t;

    localparam int DBG_REC_W = $bits(dbg_rec_t);

endpackage

// File: rtl/pciea_dbg_rec_fifo.sv
// Generic first-word-fall-through FIFO for debug records (WIDTH x DEPTH, DEPTH power of 2).
// Latency: a word written on edge N is presented on rd_dat/rd_vld right after edge N.
// Backpressure: writes are dropped by the FIFO itself when full, so callers must hold on full; rd_dat is stable until rd_rdy.
module pciea_dbg_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_vld = ~empty;
    // Zero the output while empty so the visible record is never stale storage.
    assign rd_dat = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update on accepted writes and reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage array, written only on accepted writes; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/pciea_dbg_sel_sampler.sv
// Walks dbg_sel over [SEL_FIRST..SEL_LAST], waits SETTLE cycles per select, snapshots both debug channels into a FIFO.
// Latency: sample edge to rec_valid is 2 cycles minimum; one select step costs SETTLE+3 cycles when the FIFO has room.
// Backpressure: a full FIFO stalls the FSM in PUSH0/PUSH1 with the select held; records are never dropped.
// PCIEA_DBG_CCIX_CAPTURE_EN adds rec_ccix, carrying dbg_ccix_out captured with the channel 0 record.
module pciea_dbg_sel_sampler
    import pciea_dbg_pkg::*;
#(
    parameter int SEL_FIRST  = 0,
    parameter int SEL_LAST   = 63,
    parameter int SETTLE     = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    output logic                  busy,
    output logic                  done,
    input  logic [DBG_DATA_W-1:0] dbg_data0_out,
    input  logic [DBG_CTRL_W-1:0] dbg_ctrl0_out,
    output logic [DBG_SEL_W-1:0]  dbg_sel0,
    input  logic [DBG_DATA_W-1:0] dbg_data1_out,
    input  logic [DBG_CTRL_W-1:0] dbg_ctrl1_out,
    output logic [DBG_SEL_W-1:0]  dbg_sel1,
    input  logic [DBG_CCIX_W-1:0] dbg_ccix_out,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [DBG_DATA_W-1:0] rec_data,
    output logic [DBG_CTRL_W-1:0] rec_ctrl,
    output logic [DBG_SEL_W-1:0]  rec_sel,
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
    output logic [DBG_CCIX_W-1:0] rec_ccix,
`endif
    output logic                  rec_ch
);

    localparam logic [DBG_SEL_W-1:0] SEL_FIRST_V = DBG_SEL_W'(SEL_FIRST);
    localparam logic [DBG_SEL_W-1:0] SEL_LAST_V  = DBG_SEL_W'(SEL_LAST);
    localparam logic [3:0]           SETTLE_LD   = 4'(SETTLE - 1);

    dbg_state_t            state;
    dbg_state_t            state_nxt;
    logic [DBG_SEL_W-1:0]  idx;
    logic [DBG_SEL_W-1:0]  idx_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  cont_q;
    logic                  cont_nxt;
    logic                  stop_seen;
    logic                  stop_nxt;
    logic                  done_nxt;
    logic                  sample;
    logic                  push;
    logic                  fifo_full;
    logic [DBG_DATA_W-1:0] hold0_data;
    logic [DBG_CTRL_W-1:0] hold0_ctrl;
    logic [DBG_DATA_W-1:0] hold1_data;
    logic [DBG_CTRL_W-1:0] hold1_ctrl;
    dbg_rec_t              rec0;
    dbg_rec_t              rec1;
    dbg_rec_t              push_rec;
    dbg_rec_t              pop_rec;

`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
    logic [DBG_CCIX_W-1:0] hold_ccix;
`else
    logic                  ccix_unused;
    assign ccix_unused = ^dbg_ccix_out;
`endif

    // Both selects are the registered scan index.
    assign dbg_sel0 = idx;
    assign dbg_sel1 = idx;
    assign busy     = (state != ST_IDLE);

    // Assemble the two candidate records from the holding registers.
    always_comb begin
        rec0      = '0;
        rec1      = '0;
        rec0.data = hold0_data;
        rec0.ctrl = hold0_ctrl;
        rec0.sel  = idx;
        rec0.ch   = 1'b0;
        rec1.data = hold1_data;
        rec1.ctrl = hold1_ctrl;
        rec1.sel  = idx;
        rec1.ch   = 1'b1;
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
        rec0.ccix = hold_ccix;
`endif
    end

    // Next-state, index and control decode for the scan FSM.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        cont_nxt  = cont_q;
        stop_nxt  = stop_seen | (stop & (state != ST_IDLE));
        done_nxt  = 1'b0;
        sample    = 1'b0;
        push      = 1'b0;
        push_rec  = (state == ST_PUSH1) ? rec1 : rec0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    idx_nxt   = SEL_FIRST_V;
                    cnt_nxt   = SETTLE_LD;
                    cont_nxt  = continuous;
                    stop_nxt  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    sample    = 1'b1;
                    state_nxt = ST_PUSH0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_PUSH0: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    state_nxt = ST_PUSH1;
                end
            end
            ST_PUSH1: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Compare against SEL_LAST before incrementing so 63 never overflows.
                if (stop_seen || stop) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (idx == SEL_LAST_V) begin
                    if (cont_q) begin
                        idx_nxt   = SEL_FIRST_V;
                        cnt_nxt   = SETTLE_LD;
                        state_nxt = ST_SETTLE;
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    idx_nxt   = idx + DBG_SEL_W'(1);
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, scan index and control flags.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= ST_IDLE;
            idx       <= SEL_FIRST_V;
            cnt       <= '0;
            cont_q    <= 1'b0;
            stop_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            cont_q    <= cont_nxt;
            stop_seen <= stop_nxt;
            done      <= done_nxt;
        end
    end

    // Snapshot both channels on the last settle cycle.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            hold0_data <= '0;
            hold0_ctrl <= '0;
            hold1_data <= '0;
            hold1_ctrl <= '0;
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
            hold_ccix  <= '0;
`endif
        end else if (sample) begin
            hold0_data <= dbg_data0_out;
            hold0_ctrl <= dbg_ctrl0_out;
            hold1_data <= dbg_data1_out;
            hold1_ctrl <= dbg_ctrl1_out;
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
            hold_ccix  <= dbg_ccix_out;
`endif
        end
    end

    pciea_dbg_rec_fifo #(
        .WIDTH (DBG_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk    (user_clk),
        .rst_n  (user_rst_n),
        .wr_vld (push),
        .wr_dat (push_rec),
        .full   (fifo_full),
        .rd_vld (rec_valid),
        .rd_rdy (rec_ready),
        .rd_dat (pop_rec)
    );

    assign rec_data = pop_rec.data;
    assign rec_ctrl = pop_rec.ctrl;
    assign rec_sel  = pop_rec.sel;
    assign rec_ch   = pop_rec.ch;
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
    assign rec_ccix = pop_rec.ccix;
`endif

endmodule

// File: tb/tb_pciea_dbg_sel_sampler.sv
// Bench for pciea_dbg_sel_sampler: three instances (default range, 4..6 continuous, SETTLE=4 with slow source).
// Each debug source returns data derived from the select it saw LAT cycles earlier.
// Accepted records are compared with the k-th record a scan must produce, computed from k alone.
`timescale 1ns/1ps
module tb_pciea_dbg_sel_sampler;

    localparam int NI = 3;

    function automatic int first_of(input int i);
        return (i == 1) ? 4 : 0;
    endfunction
    function automatic int last_of(input int i);
        return (i == 1) ? 6 : 63;
    endfunction
    function automatic int settle_of(input int i);
        return (i == 2) ? 4 : 2;
    endfunction
    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    // Channel 1 data is the inverse of channel 0 so a channel swap is visible.
    function automatic logic [255:0] mdata(input logic [5:0] s, input logic ch);
        logic [255:0] v;
        v = {32{s, 2'b00}};
        return ch ? ~v : v;
    endfunction
    function automatic logic [31:0] mctrl(input logic [5:0] s, input logic ch);
        return {26'd0, s} + (ch ? 32'd256 : 32'd0);
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start     [NI];
    logic         stop      [NI];
    logic         cont      [NI];
    logic         busy      [NI];
    logic         done      [NI];
    logic [255:0] d0        [NI];
    logic [255:0] d1        [NI];
    logic [31:0]  c0        [NI];
    logic [31:0]  c1        [NI];
    logic [5:0]   sel0      [NI];
    logic [5:0]   sel1      [NI];
    logic [129:0] ccix;
    logic         rec_valid [NI];
    logic         rec_ready [NI];
    logic [255:0] rec_data  [NI];
    logic [31:0]  rec_ctrl  [NI];
    logic [5:0]   rec_sel   [NI];
    logic         rec_ch    [NI];
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
    logic [129:0] rec_ccix  [NI];
`endif

    int         n_checks;
    int         n_errors;
    int         rcnt       [NI];
    int         done_cnt   [NI];
    int         ready_mode [NI];
    int         wraps      [NI];
    logic       prev_done  [NI];
    logic       hold_pend  [NI];
    logic [5:0] prev_sel   [NI];
    logic [5:0] hist       [NI][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pciea_dbg_sel_sampler #(
            .SEL_FIRST  (first_of(g)),
            .SEL_LAST   (last_of(g)),
            .SETTLE     (settle_of(g)),
            .FIFO_DEPTH (16)
        ) u_dut (
            .user_clk      (clk),
            .user_rst_n    (rst_n),
            .start         (start[g]),
            .stop          (stop[g]),
            .continuous    (cont[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .dbg_data0_out (d0[g]),
            .dbg_ctrl0_out (c0[g]),
            .dbg_sel0      (sel0[g]),
            .dbg_data1_out (d1[g]),
            .dbg_ctrl1_out (c1[g]),
            .dbg_sel1      (sel1[g]),
            .dbg_ccix_out  (ccix),
            .rec_valid     (rec_valid[g]),
            .rec_ready     (rec_ready[g]),
            .rec_data      (rec_data[g]),
            .rec_ctrl      (rec_ctrl[g]),
            .rec_sel       (rec_sel[g]),
`ifdef PCIEA_DBG_CCIX_CAPTURE_EN
            .rec_ccix      (rec_ccix[g]),
`endif
            .rec_ch        (rec_ch[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Debug sources, consumer and record scoreboard, all evaluated at the falling edge.
    initial begin : model_mon
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin : per_inst
                int         n;
                logic [5:0] es;
                logic       ech;
                for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = sel0[i];
                d0[i] = mdata(hist[i][lat_of(i)], 1'b0);
                d1[i] = mdata(hist[i][lat_of(i)], 1'b1);
                c0[i] = mctrl(hist[i][lat_of(i)], 1'b0);
                c1[i] = mctrl(hist[i][lat_of(i)], 1'b1);

                if (busy[i] === 1'b1) begin
                    chk("sel_range", 256'((int'(sel0[i]) >= first_of(i)) && (int'(sel0[i]) <= last_of(i))), 256'(1));
                    if (prev_sel[i] == 6'(last_of(i)) && sel0[i] == 6'(first_of(i))) wraps[i]++;
                end
                prev_sel[i] = sel0[i];

                if (done[i] === 1'b1) begin
                    done_cnt[i]++;
                    chk("done_width", 256'(prev_done[i]), 256'(0));
                    chk("busy_at_done", 256'(busy[i]), 256'(0));
                end
                prev_done[i] = done[i];

                if (hold_pend[i]) chk("valid_held", 256'(rec_valid[i]), 256'(1));

                case (ready_mode[i])
                    0:       rec_ready[i] = 1'b1;
                    1:       rec_ready[i] = ($urandom_range(0, 3) != 0);
                    default: rec_ready[i] = 1'b0;
                endcase

                if (rec_valid[i] === 1'b1) begin
                    n   = last_of(i) - first_of(i) + 1;
                    es  = 6'(first_of(i) + (rcnt[i] / 2) % n);
                    ech = ((rcnt[i] % 2) == 1);
                    chk("rec_sel", 256'(rec_sel[i]), 256'(es));
                    chk("rec_ch", 256'(rec_ch[i]), 256'(ech));
                    chk("rec_data", rec_data[i], mdata(es, ech));
                    chk("rec_ctrl", 256'(rec_ctrl[i]), 256'(mctrl(es, ech)));
                    if (rec_ready[i]) rcnt[i]++;
                end
                hold_pend[i] = (rec_valid[i] === 1'b1) && !rec_ready[i];
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i, input logic c);
        cont[i]  = c;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic wait_drained(input int i);
        int t;
        t = 0;
        while ((busy[i] !== 1'b0 || rec_valid[i] !== 1'b0) && t < 5000) begin
            step();
            t++;
        end
        chk("drain_timeout", 256'(t < 5000), 256'(1));
        step();
    endtask

    task automatic wait_sel(input int i, input logic [5:0] s);
        int t;
        t = 0;
        while (sel0[i] !== s && t < 5000) begin
            step();
            t++;
        end
        chk("sel_timeout", 256'(t < 5000), 256'(1));
    endtask

    task automatic clear_counts(input int i);
        rcnt[i]     = 0;
        done_cnt[i] = 0;
        wraps[i]    = 0;
    endtask

    initial begin : main
        logic [159:0] rnd;
        int           dsave;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rnd      = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ccix     = rnd[129:0];
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; stop[i] = 1'b0; cont[i] = 1'b0;
            rec_ready[i] = 1'b1; ready_mode[i] = 0;
            prev_done[i] = 1'b0; hold_pend[i] = 1'b0; prev_sel[i] = 6'(first_of(i));
            for (int k = 0; k < 4; k++) hist[i][k] = 6'(first_of(i));
            clear_counts(i);
        end

        // Reset state
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", 256'(busy[i]), 256'(0));
            chk("rst_done", 256'(done[i]), 256'(0));
            chk("rst_valid", 256'(rec_valid[i]), 256'(0));
            chk("rst_sel0", 256'(sel0[i]), 256'(first_of(i)));
            chk("rst_sel1", 256'(sel1[i]), 256'(first_of(i)));
            chk("rst_data", rec_data[i], 256'(0));
            chk("rst_ctrl", 256'(rec_ctrl[i]), 256'(0));
            chk("rst_rsel", 256'(rec_sel[i]), 256'(0));
            chk("rst_ch", 256'(rec_ch[i]), 256'(0));
        end
        rst_n = 1'b1;
        step();

        // Single scan with an always-ready consumer
        pulse_start(0, 1'b0);
        chk("busy_after_start", 256'(busy[0]), 256'(1));
        wait_drained(0);
        chk("single_count", 256'(rcnt[0]), 256'(128));
        chk("single_done", 256'(done_cnt[0]), 256'(1));
        chk("single_busy", 256'(busy[0]), 256'(0));

        // Backpressure from select 30: 16 records fill the FIFO, scan stalls at select 38
        clear_counts(0);
        pulse_start(0, 1'b0);
        wait_sel(0, 6'd30);
        ready_mode[0] = 2;
        repeat (44) step();
        chk("bp_sel0_a", 256'(sel0[0]), 256'(38));
        chk("bp_sel1_a", 256'(sel1[0]), 256'(38));
        repeat (16) step();
        chk("bp_sel0_b", 256'(sel0[0]), 256'(38));
        chk("bp_valid", 256'(rec_valid[0]), 256'(1));
        chk("bp_busy", 256'(busy[0]), 256'(1));
        ready_mode[0] = 1;
        wait_drained(0);
        chk("bp_count", 256'(rcnt[0]), 256'(128));
        chk("bp_done", 256'(done_cnt[0]), 256'(1));

        // Second start while busy is ignored
        clear_counts(0);
        pulse_start(0, 1'b0);
        wait_sel(0, 6'd10);
        pulse_start(0, 1'b0);
        wait_drained(0);
        chk("rstart_count", 256'(rcnt[0]), 256'(128));
        chk("rstart_done", 256'(done_cnt[0]), 256'(1));
        ready_mode[0] = 0;

        // Continuous 4..6, stop on entering select 4 after the second wrap: 7 selects, 14 records
        ready_mode[1] = 1;
        clear_counts(1);
        pulse_start(1, 1'b1);
        begin
            int t;
            t = 0;
            while (wraps[1] < 2 && t < 5000) begin
                step();
                t++;
            end
            chk("wrap_timeout", 256'(t < 5000), 256'(1));
        end
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        wait_drained(1);
        chk("cont_count", 256'(rcnt[1]), 256'(14));
        chk("cont_even", 256'(rcnt[1] % 2), 256'(0));
        chk("cont_done", 256'(done_cnt[1]), 256'(1));
        chk("cont_busy", 256'(busy[1]), 256'(0));

        // Reset in the middle of a scan
        clear_counts(0);
        pulse_start(0, 1'b0);
        wait_sel(0, 6'd20);
        dsave = done_cnt[0];
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) hold_pend[i] = 1'b0;
        #1;
        chk("mrst_busy", 256'(busy[0]), 256'(0));
        chk("mrst_valid", 256'(rec_valid[0]), 256'(0));
        chk("mrst_sel0", 256'(sel0[0]), 256'(0));
        chk("mrst_sel1", 256'(sel1[0]), 256'(0));
        rcnt[0] = 0;
        repeat (3) @(posedge clk);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("mrst_no_done", 256'(done_cnt[0]), 256'(dsave));
        ready_mode[0] = 1;
        pulse_start(0, 1'b0);
        wait_drained(0);
        chk("mrst_count", 256'(rcnt[0]), 256'(128));
        chk("mrst_done", 256'(done_cnt[0] - dsave), 256'(1));

        // SETTLE=4 against a source with 3 cycles of select latency
        ready_mode[2] = 1;
        clear_counts(2);
        pulse_start(2, 1'b0);
        wait_drained(2);
        chk("slow_count", 256'(rcnt[2]), 256'(128));
        chk("slow_done", 256'(done_cnt[2]), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pciea_dbg_sel_sampler.md
Name: pciea_dbg_sel_sampler

Overview:
- Consumer end of the PCIe port debug interface. It drives dbg_sel0 and dbg_sel1 and samples the port's dbg_data/dbg_ctrl buses.
- On a start pulse it walks a select range. At each select it waits a settle window, snapshots both debug channels, and pushes tagged records into an internal FIFO.
- Records drain to a valid/ready stream consumed by the debug readout logic (ILA/AXI bridge).

Parameters:
- SEL_FIRST, 0: first select value scanned (0..63).
- SEL_LAST, 63: last select value scanned; must be >= SEL_FIRST.
- SETTLE, 2: cycles the select is held before sampling (1..15).
- FIFO_DEPTH, 16: record FIFO depth; power of 2, >= 4.

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- stop  in  1  one-cycle pulse; ends a continuous scan.
- continuous  in  1  sampled at start; 1 = wrap and repeat until stop.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan terminates.
- dbg_data0_out  in  256  channel 0 debug data.
- dbg_ctrl0_out  in  32  channel 0 debug control.
- dbg_sel0  out  6  channel 0 select.
- dbg_data1_out  in  256  channel 1 debug data.
- dbg_ctrl1_out  in  32  channel 1 debug control.
- dbg_sel1  out  6  channel 1 select.
- dbg_ccix_out  in  130  CCIX debug bus; used only with the optional feature.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_data  out  256  captured data.
- rec_ctrl  out  32  captured control.
- rec_sel  out  6  select value at capture.
- rec_ch  out  1  0 = channel 0, 1 = channel 1.

Behaviour:
- Clocking and reset: one clock (user_clk). Reset user_rst_n is asynchronous, active-low.
- Reset values:
  - busy=0, done=0, rec_valid=0.
  - dbg_sel0 = dbg_sel1 = SEL_FIRST.
  - FIFO empty; all rec_* fields 0.
- dbg_sel0 and dbg_sel1 are registered and always carry the same value (the scan index).
- FSM states: IDLE, SETTLE, PUSH0, PUSH1, NEXT.
- IDLE:
  - start=1 latches continuous, sets the index to SEL_FIRST, loads the settle counter with SETTLE-1, and moves to SETTLE. busy=1 from the next cycle.
  - start while busy is ignored.
- SETTLE:
  - Counter decrements each cycle. The select is stable for exactly SETTLE cycles before sampling.
  - When the counter reaches 0, both channels' data and ctrl are registered into holding registers on that edge, and the FSM moves to PUSH0.
- PUSH0: pushes the channel 0 record {hold0, index, ch=0} when the FIFO is not full, then moves to PUSH1. If the FIFO is full it stalls in PUSH0 and the select is held. Records are never dropped.
- PUSH1: pushes the channel 1 record the same way, then moves to NEXT.
- NEXT, evaluated in order:
  1. stop seen since start (a sticky flag set by a stop pulse in any busy state): go to IDLE and pulse done.
  2. index == SEL_LAST and not continuous: go to IDLE and pulse done.
  3. index == SEL_LAST and continuous: index wraps to SEL_FIRST, go to SETTLE.
  4. Otherwise: index+1, go to SETTLE.
- Record count: a single scan produces exactly 2*(SEL_LAST-SEL_FIRST+1) records, 128 at defaults.
- The select range is never exceeded. Index arithmetic is 6-bit, and SEL_LAST=63 does not overflow because the wrap compare precedes the increment.
- FIFO:
  - First-word-fall-through. rec_* are valid whenever rec_valid=1 and are held stable until rec_valid&rec_ready.
  - Simultaneous push and pop when full is legal only if the pop occurs; the push is gated on not-full in the same cycle.
  - Minimum latency from sample edge to rec_valid is 2 cycles.
- After done, the FIFO continues draining; busy is already 0.
- Reset mid-scan aborts immediately. FIFO contents are lost and no done pulse is generated.

Optional Feature:
- Macro: PCIEA_DBG_CCIX_CAPTURE_EN.
- Defined:
  - Adds output port rec_ccix [129:0].
  - dbg_ccix_out is captured in the SETTLE sampling cycle and attached to the channel 0 record only; the channel 1 record carries rec_ccix=0.
  - The FIFO width grows by 130.
- Undefined: no rec_ccix port, dbg_ccix_out is unused, and no CCIX storage is instantiated.

Decomposition:
- Package pciea_dbg_pkg holds:
  - DBG_DATA_W=256, DBG_CTRL_W=32, DBG_SEL_W=6, DBG_CCIX_W=130.
  - The FSM state enum.
  - A packed record struct {data, ctrl, sel, ch[, ccix]}.
- Sub-module pciea_dbg_rec_fifo: a generic FWFT synchronous FIFO (width, depth) with full/empty. It is instantiated once and reusable by other debug taps.

Test Plan:
- Single scan, defaults: the model returns data = {32{sel,2'b00}}, ctrl = sel+ch*256 with 1-cycle select latency; rec_ready=1; one start. Required: 128 records in order sel 0..63, ch 0 then 1, payloads matching; done pulses once; busy drops.
- Backpressure: rec_ready=0 for 40 cycles mid-scan. Required: FSM stalls with dbg_sel0 frozen; no record lost or duplicated; final count is 128.
- Continuous: SEL_FIRST=4, SEL_LAST=6, continuous=1, stop pulsed after the second wrap. Required: the sel sequence 4,5,6,4,5,6,... ends only at a NEXT boundary; record count is even; done is a single pulse.
- Start while busy: a second start pulse at the 10th select. Required: ignored; exactly 128 records.
- Reset mid-scan: assert user_rst_n=0 at select 20 and hold 3 cycles. Required: immediate busy=0, rec_valid=0, dbg_sel=SEL_FIRST, no done. A subsequent start yields a clean 128-record scan.
- SETTLE=4 with a 3-cycle model latency. Required: each record carries data for its own sel; there are no stale-select values.
